// File: rtl/openpiton_send_arbiter.sv
// openpiton_send_arbiter: round-robin arbiter sharing the OpenPiton NoC send
// path among NUM_REQ producers. Holds its grant while the NoC back-pressures
// and keeps a saturating stall counter for debug.
//
// Optional build macro XCTCMSG_SEND_ARB_OUTPUT_REG_EN: adds a 2-entry skid
// buffer on the output side, so req_ready no longer depends combinationally
// on out_ready. Without the macro the arbiter is zero-latency.

package openpiton_send_arbiter_pkg;
    typedef struct packed {
        logic [2:0]  msg_type;
        logic [7:0]  src_id;
        logic [63:0] payload;
    } interface_send_data_t;
endpackage

module openpiton_send_arbiter
    import openpiton_send_arbiter_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int STALL_CNT_W = 16,
    localparam int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                 [NUM_REQ-1:0]    req_valid,
    output logic                 [NUM_REQ-1:0]    req_ready,
    input  interface_send_data_t [NUM_REQ-1:0]    req_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output interface_send_data_t                  out_data,
    output logic                 [IDX_W-1:0]      out_grant,
    output logic                 [STALL_CNT_W-1:0] stall_count
);

    // (base + inc) mod NUM_REQ, for inc < NUM_REQ
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned       inc);
        int unsigned s;
        s = 32'(base) + inc;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return s[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] grant;
    logic             stall_event;

    // Round-robin search: first valid requester starting at rr_ptr; scanning
    // the rotation backwards lets the closest candidate win without a flag.
    always_comb begin
        rr_pick = rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid[wrap_add(rr_ptr, NUM_REQ - 1 - k)])
                rr_pick = wrap_add(rr_ptr, NUM_REQ - 1 - k);
        end
    end

    // Saturating stall counter, only cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall_event && (stall_count != {STALL_CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

`ifdef XCTCMSG_SEND_ARB_OUTPUT_REG_EN

    // Skid buffer: acceptance is decoupled from out_ready, so no lock needed.
    interface_send_data_t buf_data  [2];
    logic [IDX_W-1:0]     buf_grant [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           buf_cnt;
    logic                 buf_not_full;
    logic                 accept;
    logic                 pop;

    assign grant        = rst_n ? rr_pick : '0;
    assign buf_not_full = rst_n & (buf_cnt != 2'd2);
    assign accept       = buf_not_full & req_valid[grant];
    assign out_valid    = (buf_cnt != 2'd0);
    assign pop          = out_valid & out_ready;
    assign stall_event  = out_valid & ~out_ready;
    assign out_data     = rst_n ? buf_data[rd_ptr]  : req_data[0];
    assign out_grant    = rst_n ? buf_grant[rd_ptr] : '0;

    // Ready goes only to the selected requester while there is room
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign req_ready[i] = buf_not_full & (grant == IDX_W'(i));
    end

    // Rotation pointer advances on acceptance into the buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr <= '0;
        else if (accept)
            rr_ptr <= wrap_add(grant, 1);
    end

    // Buffer occupancy and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (accept) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            case ({accept, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

    // Buffer payload storage (no reset needed, qualified by buf_cnt)
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_data[wr_ptr]  <= req_data[grant];
            buf_grant[wr_ptr] <= grant;
        end
    end

`else

    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic             handshake;

    // A stalled grant is frozen on lock_idx until its handshake completes
    assign grant       = !rst_n ? '0 : (locked ? lock_idx : rr_pick);
    assign out_valid   = rst_n & (locked ? req_valid[lock_idx] : |req_valid);
    assign out_data    = req_data[grant];
    assign out_grant   = grant;
    assign handshake   = out_valid & out_ready;
    assign stall_event = out_valid & ~out_ready;

    // Zero-latency ready, only to the granted requester
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
        assign req_ready[i] = out_ready & out_valid & (grant == IDX_W'(i));
    end

    // Rotation pointer and grant lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
        end else if (handshake) begin
            rr_ptr <= wrap_add(grant, 1);
            locked <= 1'b0;
        end else if (stall_event) begin
            locked   <= 1'b1;
            lock_idx <= grant;
        end else begin
            // locked requester withdrew its request: release, keep rr_ptr
            locked <= 1'b0;
        end
    end

    // A locked requester must keep its request up until it is accepted
    locked_req_held: assert property (@(posedge clk) disable iff (!rst_n)
                                      locked |-> req_valid[lock_idx]);

`endif

endmodule
